execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Y86-64 pipeline execute (E) stage: consumes decoded operands, drives the 64-bit ALU (add/sub/and/xor),
//  owns the condition-code register (ZF/SF/OF), evaluates Cnd for cmovXX/jXX, registers results for memory stage.
//  Sits between decode and memory; one-entry output register with valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH   64   datapath width (valA/valB/valC/valE)
//  STATW   2    status code width (AOK=1, HLT=2, ADR=3, INS=4 encoded in 3 bits when STATW=3)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      synchronous, active-low reset
//  flush      in   1      squash: drop held result, refuse input this cycle
//  in_valid   in   1      decode presents an instruction
//  in_ready   out  1      stage can accept (= !out_valid | out_ready) & !flush
//  in_icode   in   4      Y86 icode
//  in_ifun    in   4      Y86 ifun
//  in_stat    in   STATW  status from decode
//  in_valA    in   WIDTH  operand A
//  in_valB    in   WIDTH  operand B
//  in_valC    in   WIDTH  immediate/displacement
//  in_dstE    in   4      dest reg for valE (0xF = none)
//  in_dstM    in   4      dest reg for memory load (pass-through)
//  out_valid  out  1      result held
//  out_ready  in   1      memory stage accepts
//  out_icode  out  4      / out_stat out STATW / out_valA out WIDTH / out_dstM out 4: registered pass-through
//  out_valE   out  WIDTH  ALU result
//  out_cnd    out  1      condition outcome
//  out_dstE   out  4      in_dstE, or 0xF when cmovXX with cnd=0
//  cc_zf/cc_sf/cc_of out 1 each: current CC register
// BEHAVIOUR
//  Reset (reset_n=0 at edge): out_valid=0, all out_* data=0, out_dstE/out_dstM=0xF, CC={ZF=1,SF=0,OF=0}.
//  Accept: in_valid & in_ready at edge -> outputs load, out_valid=1. Latency 1 cycle; throughput 1/cycle.
//  Hold: out_valid & !out_ready -> all out_* stable, in_ready=0. Drain w/o new input -> out_valid=0.
//  ALU select (aluA,aluB,fn): rrmov/cmov(2): valA,0,add; irmov(3): valC,0,add; rmmov/mrmov(4,5): valC,valB,add;
//   OPq(6): valA,valB,ifun (0 add,1 sub=B-A,2 and,3 xor); call/push(8,A): -8,valB,add; ret/pop(9,B): +8,valB,add;
//   halt/nop/jXX: valE=0. Arithmetic mod 2^WIDTH.
//  CC update only on accepted OPq with in_stat==AOK and !flush: ZF=(valE==0); SF=valE[63];
//   OF add: A,B same sign & valE sign differs; sub: A,B signs differ & valE sign != B sign; and/xor: 0.
//  Cnd from CC value BEFORE this edge's update: ifun 0 always,1 le (SF^OF)|ZF,2 l SF^OF,3 e ZF,4 ne !ZF,
//   5 ge !(SF^OF),6 g !(SF^OF)&!ZF; ifun>6 -> 0. out_cnd meaningful for icode 2/7, else 0.
//  Back-to-back OPq then cmov/jXX: second sees first's CC (CC written at first's accept edge).
//  flush: at edge clears out_valid, no accept, no CC write; flush & reset -> reset wins.
//  Reset mid-transfer: held result discarded, CC to reset value; no partial state survives.
//  Non-AOK in_stat: instruction still passes (stat forwarded), CC untouched.
// STRUCTURE
//  Package y86_pkg: icode constants (I_HALT..I_POPQ), ALU fn codes (ALU_ADD/SUB/AND/XOR), cond codes
//   (C_YES..C_G), stat codes (S_AOK/HLT/ADR/INS), REG_NONE=4'hF.
//  Sub-module: alu_64 (combinational add/sub/and/xor + OF/ZF/SF flags) instantiated once;
//   operand mux, cond logic, CC reg, output reg in execute_stage.
// TESTING
//  1 OPq xor valA=0x0A valB=0x0F -> valE=0x05, next cycle CC ZF=0 SF=0 OF=0, out_valid=1 one cycle after accept.
//  2 OPq add valA=1 valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0x8000_0000_0000_0000, SF=1 OF=1 ZF=0.
//  3 OPq sub valA=valB=0x25 -> valE=0, ZF=1; next cmovle (2,1) dstE=3 -> cnd=1, out_dstE=3;
//    then cmovg -> cnd=0, out_dstE=0xF.
//  4 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, no CC change;
//    release -> both instrs drained in order.
//  5 OPq with in_stat=ADR -> CC unchanged, out_stat=ADR; flush asserted with held result -> out_valid=0 next cycle.
//  6 reset_n low mid-hold -> out_valid=0, CC=Z1/S0/O0 at next edge; push valB=0x100 after -> valE=0xF8.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage.
// Holds the instruction codes, ALU function codes, condition codes, status
// codes and the "no register" id, plus the jXX/cmovXX condition evaluator.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU function codes (ifun of OPq)
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  // Condition codes (ifun of cmovXX / jXX)
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  // Status codes
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Condition outcome for a given ifun and CC value; unknown ifun -> false.
  function automatic logic cond_eval(input logic [3:0] ifun,
                                     input logic zf, input logic sf,
                                     input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_64.sv
// Combinational Y86 ALU: add, sub (b - a), and, xor, with ZF/SF/OF flags.
// Ports: a, b operands; fn function code; y result; zf/sf/of flags
// (of is zero for the logical functions).
module alu_64
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  output logic [WIDTH-1:0] y,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  always_comb begin
    y  = '0;
    of = 1'b0;
    case (fn)
      ALU_ADD: begin
        y  = a + b;
        of = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        y  = b - a;
        of = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != b[WIDTH-1]);
      end
      ALU_AND: y = a & b;
      default: y = a ^ b;
    endcase
    zf = (y == '0);
    sf = y[WIDTH-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 pipeline execute stage.
// Selects ALU operands per icode, owns the ZF/SF/OF condition-code register,
// evaluates Cnd for cmovXX/jXX and holds one result for the memory stage.
// Ports: clk, reset_n (sync, active low), flush; in_* decode side with
// in_valid/in_ready; out_* memory side with out_valid/out_ready;
// cc_zf/cc_sf/cc_of expose the current condition codes.
module execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STATW = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_icode,
  input  logic [3:0]       in_ifun,
  input  logic [STATW-1:0] in_stat,
  input  logic [WIDTH-1:0] in_valA,
  input  logic [WIDTH-1:0] in_valB,
  input  logic [WIDTH-1:0] in_valC,
  input  logic [3:0]       in_dstE,
  input  logic [3:0]       in_dstM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [STATW-1:0] out_stat,
  output logic [WIDTH-1:0] out_valA,
  output logic [WIDTH-1:0] out_valE,
  output logic             out_cnd,
  output logic [3:0]       out_dstE,
  output logic [3:0]       out_dstM,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [1:0]       alu_fn;
  logic             alu_zf, alu_sf, alu_of;
  logic             cnd, accept, cc_write;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALU_ADD;
    case (in_icode)
      I_RRMOVQ: alu_a = in_valA;
      I_IRMOVQ: alu_a = in_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = in_valC;
        alu_b = in_valB;
      end
      I_OPQ: begin
        alu_a  = in_valA;
        alu_b  = in_valB;
        alu_fn = in_ifun[1:0];
      end
      I_CALL, I_PUSHQ: begin
        alu_a = '0 - WIDTH'(8);
        alu_b = in_valB;
      end
      I_RET, I_POPQ: begin
        alu_a = WIDTH'(8);
        alu_b = in_valB;
      end
      default: ;
    endcase
  end

  alu_64 #(.WIDTH(WIDTH)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .fn (alu_fn),
    .y  (alu_y),
    .zf (alu_zf),
    .sf (alu_sf),
    .of (alu_of)
  );

  // Cnd uses the CC register as it stands, so an OPq accepted on the
  // previous edge is already visible to a following cmov/jXX.
  always_comb begin
    cnd = 1'b0;
    if (in_icode == I_RRMOVQ || in_icode == I_JXX)
      cnd = cond_eval(in_ifun, cc_zf, cc_sf, cc_of);
  end

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign cc_write = accept && (in_icode == I_OPQ) && (in_stat == STATW'(S_AOK));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (cc_write) begin
      cc_zf <= alu_zf;
      cc_sf <= alu_sf;
      cc_of <= alu_of;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_stat  <= '0;
      out_valA  <= '0;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      out_dstE  <= REG_NONE;
      out_dstM  <= REG_NONE;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= in_icode;
      out_stat  <= in_stat;
      out_valA  <= in_valA;
      out_valE  <= alu_y;
      out_cnd   <= cnd;
      out_dstE  <= (in_icode == I_RRMOVQ && !cnd) ? REG_NONE : in_dstE;
      out_dstM  <= in_dstM;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk;
  logic        reset_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_cnd, cc_zf, cc_sf, cc_of;
  logic [3:0]  in_icode, in_ifun, in_dstE, in_dstM;
  logic [1:0]  in_stat, out_stat;
  logic [63:0] in_valA, in_valB, in_valC, out_valA, out_valE;
  logic [3:0]  out_icode, out_dstE, out_dstM;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [3:0]  icode;
    logic [1:0]  stat;
    logic [63:0] valA;
    logic [63:0] valE;
    logic        cnd;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        zf, sf, of;
  } res_t;

  // reference state
  logic m_valid;
  res_t m_out;
  logic m_zf, m_sf, m_of;

  execute_stage #(.WIDTH(64), .STATW(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_stat(in_stat),
    .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC),
    .in_dstE(in_dstE), .in_dstM(in_dstM),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_stat(out_stat), .out_valA(out_valA),
    .out_valE(out_valE), .out_cnd(out_cnd), .out_dstE(out_dstE),
    .out_dstM(out_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_cond(input logic [3:0] f, input logic z, input logic s, input logic o);
    logic less;
    less = (s != o);
    case (f)
      4'd0: m_cond = 1'b1;
      4'd1: m_cond = less || z;
      4'd2: m_cond = less;
      4'd3: m_cond = z;
      4'd4: m_cond = !z;
      4'd5: m_cond = !less;
      4'd6: m_cond = !less && !z;
      default: m_cond = 1'b0;
    endcase
  endfunction

  // Result of one instruction given the CC value in force when it enters.
  function automatic res_t m_exec(input logic [3:0] ic, input logic [3:0] fu,
                                  input logic [1:0] st, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] c,
                                  input logic [3:0] de, input logic [3:0] dm,
                                  input logic z, input logic s, input logic o);
    res_t r;
    logic [64:0] wide;
    r = '0;
    r.icode = ic; r.stat = st; r.valA = a; r.dstM = dm; r.dstE = de;
    r.zf = z; r.sf = s; r.of = o;
    case (ic)
      4'h2: r.valE = a;
      4'h3: r.valE = c;
      4'h4, 4'h5: r.valE = c + b;
      4'h8, 4'hA: r.valE = b - 64'd8;
      4'h9, 4'hB: r.valE = b + 64'd8;
      4'h6: begin
        r.of = 1'b0;
        case (fu[1:0])
          2'd0: begin
            wide = {a[63], a} + {b[63], b};
            r.valE = wide[63:0];
            r.of = wide[64] != wide[63];
          end
          2'd1: begin
            wide = {b[63], b} - {a[63], a};
            r.valE = wide[63:0];
            r.of = wide[64] != wide[63];
          end
          2'd2: r.valE = a & b;
          default: r.valE = a ^ b;
        endcase
        r.zf = (r.valE == 64'd0);
        r.sf = r.valE[63];
      end
      default: r.valE = 64'd0;
    endcase
    if (ic == 4'h2 || ic == 4'h7) r.cnd = m_cond(fu, z, s, o);
    if (ic == 4'h2 && !r.cnd) r.dstE = 4'hF;
    return r;
  endfunction

  // One clock: check in_ready, advance the reference, check outputs after the edge.
  task automatic cycle();
    logic rdy, acc;
    res_t r;
    #1;
    rdy = (!m_valid || out_ready) && !flush;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    acc = in_valid && rdy;
    r = m_exec(in_icode, in_ifun, in_stat, in_valA, in_valB, in_valC,
               in_dstE, in_dstM, m_zf, m_sf, m_of);
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 1'b0;
      m_out = '0;
      m_out.dstE = 4'hF; m_out.dstM = 4'hF;
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_out = r;
      if (in_icode == 4'h6 && in_stat == 2'd1) begin
        m_zf = r.zf; m_sf = r.sf; m_of = r.of;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
    if (m_valid) begin
      chk("out_icode", {60'd0, out_icode}, {60'd0, m_out.icode});
      chk("out_stat", {62'd0, out_stat}, {62'd0, m_out.stat});
      chk("out_valA", out_valA, m_out.valA);
      chk("out_valE", out_valE, m_out.valE);
      chk("out_cnd", {63'd0, out_cnd}, {63'd0, m_out.cnd});
      chk("out_dstE", {60'd0, out_dstE}, {60'd0, m_out.dstE});
      chk("out_dstM", {60'd0, out_dstM}, {60'd0, m_out.dstM});
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fu, input logic [1:0] st,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de);
    in_valid = 1'b1; in_icode = ic; in_ifun = fu; in_stat = st;
    in_valA = a; in_valB = b; in_valC = c; in_dstE = de; in_dstM = 4'hF;
  endtask

  initial begin
    m_valid = 1'b0; m_out = '0; m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_icode = '0; in_ifun = '0; in_stat = 2'd1;
    in_valA = '0; in_valB = '0; in_valC = '0; in_dstE = 4'hF; in_dstM = 4'hF;
    @(posedge clk); #1;

    // Reset state
    cycle(); cycle();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dstE", {60'd0, out_dstE}, 64'hF);
    chk("rst_dstM", {60'd0, out_dstM}, 64'hF);
    chk("rst_valE", out_valE, 64'd0);
    chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    reset_n = 1'b1;

    // 1: xor
    drive(4'h6, 4'h3, 2'd1, 64'h0A, 64'h0F, 64'd0, 4'd2);
    cycle();
    chk("xor_valE", out_valE, 64'h05);
    chk("xor_valid", {63'd0, out_valid}, 64'd1);
    chk("xor_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
    in_valid = 1'b0; cycle();

    // 2: signed overflow on add
    drive(4'h6, 4'h0, 2'd1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2);
    cycle();
    chk("add_valE", out_valE, 64'h8000_0000_0000_0000);
    chk("add_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);
    in_valid = 1'b0; cycle();

    // 3: sub to zero, then cmovle / cmovg back to back
    drive(4'h6, 4'h1, 2'd1, 64'h25, 64'h25, 64'd0, 4'd2);
    cycle();
    chk("sub_valE", out_valE, 64'd0);
    chk("sub_zf", {63'd0, cc_zf}, 64'd1);
    drive(4'h2, 4'h1, 2'd1, 64'h1234, 64'd0, 64'd0, 4'd3);
    cycle();
    chk("cmovle_cnd", {63'd0, out_cnd}, 64'd1);
    chk("cmovle_dstE", {60'd0, out_dstE}, 64'd3);
    drive(4'h2, 4'h6, 2'd1, 64'h1234, 64'd0, 64'd0, 4'd3);
    cycle();
    chk("cmovg_cnd", {63'd0, out_cnd}, 64'd0);
    chk("cmovg_dstE", {60'd0, out_dstE}, 64'hF);
    in_valid = 1'b0; cycle();

    // 4: backpressure
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 2'd1, 64'd2, 64'd3, 64'd0, 4'd1);
    cycle();
    drive(4'h6, 4'h1, 2'd1, 64'd1, 64'd1, 64'd0, 4'd4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_rdy", {63'd0, in_ready}, 64'd0);
      chk("hold_valE", out_valE, 64'd5);
      chk("hold_zf", {63'd0, cc_zf}, 64'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("drain2_valE", out_valE, 64'd0);
    chk("drain2_dstE", {60'd0, out_dstE}, 64'd4);
    in_valid = 1'b0; cycle();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // 5: non-AOK status, then flush of a held result
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 2'd3, 64'd1, 64'd1, 64'd0, 4'd1);
    cycle();
    chk("adr_stat", {62'd0, out_stat}, 64'd3);
    chk("adr_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    in_valid = 1'b0; flush = 1'b1;
    cycle();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;

    // 6: reset while holding, then push
    drive(4'h6, 4'h0, 2'd1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2);
    cycle();
    reset_n = 1'b0;
    cycle();
    chk("rst2_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    reset_n = 1'b1; out_ready = 1'b1;
    drive(4'hA, 4'h0, 2'd1, 64'd0, 64'h100, 64'd0, 4'd4);
    cycle();
    chk("push_valE", out_valE, 64'hF8);
    in_valid = 1'b0; cycle();

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a, b;
      reset_n   = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_icode  = 4'($urandom_range(0, 11));
      in_ifun   = (in_icode == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
      in_stat   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 64'($urandom_range(0, 3)); b = 64'($urandom_range(0, 3)); end
        default: ;
      endcase
      in_valA = a; in_valB = b; in_valC = {$urandom, $urandom};
      in_dstE = 4'($urandom_range(0, 15));
      in_dstM = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
